pointwise_mul: RTL and testbench
================================

POINTWISE_MUL -- requirements
Module: pointwise_mul

Interface
REQ-001 Parameter LANES, default 8: coefficients per packed vector; fixed at 8 for this release.
REQ-002 Parameter W, default 8: bits per coefficient; fixed at 8 for this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a_in/b_in/mod presented.
REQ-006 in_ready  output  1  block can accept a vector pair.
REQ-007 a_in  input  64  NTT-domain vector A; lane k in bits [8k+7:8k], lane 0 in [7:0].
REQ-008 b_in  input  64  NTT-domain vector B; same packing as a_in.
REQ-009 mod  input  8  modulus; sampled with a_in/b_in.
REQ-010 out_valid  output  1  data_out holds a complete result.
REQ-011 out_ready  input  1  downstream (inverse-NTT stage) accepts result.
REQ-012 data_out  output  64  pointwise product vector; same packing as a_in; feeds the inverse-NTT data input directly.
REQ-013 mod_err  output  1  captured modulus was 0; qualified by out_valid.

Function
REQ-014 Three states SHALL exist: IDLE, CALC, DONE.
REQ-015 in_ready SHALL equal (state==IDLE) and not rst; no combinational path from out_ready to in_ready.
REQ-016 IDLE: on an edge with in_valid and in_ready high, the block SHALL register a_in, b_in, mod, clear the lane counter to 0, clear data_out to 0, and enter CALC.
REQ-017 CALC: each edge SHALL write lane k of data_out with (a_k * b_k) mod m, using a 16-bit unsigned product and the captured m, then increment k.
REQ-018 Exactly one lane SHALL be computed per cycle, lanes 0..7 in order; after the lane-7 edge the state SHALL become DONE.
REQ-019 Latency: acceptance edge E0 -> lanes written on E1..E8 -> out_valid high after E8; next acceptance no earlier than one edge after the output handshake.
REQ-020 Inputs with a_k or b_k >= m SHALL be reduced correctly (full 16-bit product reduced, no pre-reduction assumed).
REQ-021 m==1 SHALL produce all-zero lanes, mod_err=0.
REQ-022 m==0 SHALL produce all-zero lanes and mod_err=1; CALC still takes 8 cycles.
REQ-023 DONE: out_valid=1; data_out and mod_err SHALL remain stable until an edge with out_ready high, which returns the state to IDLE and clears out_valid.
REQ-024 out_valid SHALL be 0 in IDLE and CALC; out_ready outside DONE SHALL be ignored.
REQ-025 Changes on a_in/b_in/mod/in_valid during CALC or DONE SHALL have no effect.
REQ-026 data_out contents during CALC are not defined for the consumer; only out_valid qualifies them.

Reset
REQ-027 On an edge with rst high: state=IDLE, lane counter=0, data_out=0, out_valid=0, mod_err=0, captured operands=0.
REQ-028 rst SHALL take priority over every handshake on the same edge; a reset during CALC or DONE SHALL discard the operation with no out_valid pulse.
REQ-029 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-030 m=17, a lanes 1..8 (lane 0 = 1), b all 2 -> after 8 cycles out_valid=1, data_out lanes 2,4,6,8,10,12,14,16, mod_err=0.
REQ-031 m=17, all a=b=16 -> every lane 1; m=251, all a=b=200 -> every lane 91.
REQ-032 Back-pressure: out_ready low for 5 cycles in DONE -> data_out, out_valid stable, in_ready=0, new in_valid ignored; out_ready high -> IDLE next cycle, in_ready=1.
REQ-033 rst asserted on the edge that would write lane 4 -> next cycle state IDLE, out_valid=0, data_out=0, in_ready=1; subsequent vector processes normally.
REQ-034 m=0, any operands -> out_valid after 8 cycles, data_out=0, mod_err=1; following m=1 vector -> data_out=0, mod_err=0.
REQ-035 Back-to-back: in_valid held high, out_ready held high -> one result per 10 cycles, no vector dropped or duplicated, results in input order.

Source files
------------

// File: rtl/pointwise_mul.sv
// Pointwise modular multiply of two packed NTT-domain vectors.
// One lane per cycle; result held until the downstream stage takes it.
module pointwise_mul #(
  parameter int LANES = 8,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES*W-1:0] a_in,
  input  logic [LANES*W-1:0] b_in,
  input  logic [W-1:0]     mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES*W-1:0] data_out,
  output logic             mod_err
);

  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [LANES*W-1:0]   a_q, a_d;
  logic [LANES*W-1:0]   b_q, b_d;
  logic [W-1:0]         mod_q, mod_d;
  logic [LANES*W-1:0]   data_q, data_d;
  logic                 err_q, err_d;
  logic                 ov_q, ov_d;

  logic [W-1:0]         a_lane;
  logic [W-1:0]         b_lane;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         red;

  // Select the current lane and reduce its full-width product by the modulus
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        a_lane = a_q[k*W +: W];
        b_lane = b_q[k*W +: W];
      end
    end
    prod = {{W{1'b0}}, a_lane} * {{W{1'b0}}, b_lane};
    if (mod_q == '0) begin
      red = '0;
    end else begin
      red = W'(prod % {{W{1'b0}}, mod_q});
    end
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    a_d     = a_q;
    b_d     = b_q;
    mod_d   = mod_q;
    data_d  = data_q;
    err_d   = err_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          mod_d   = mod;
          err_d   = (mod == '0);
          lane_d  = '0;
          data_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_q == LW'(k)) begin
            data_d[k*W +: W] = red;
          end
        end
        lane_d = lane_q + 1'b1;
        if (lane_q == LW'(LANES-1)) begin
          state_d = DONE;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mod_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign data_out  = data_q;
  assign mod_err   = err_q;

endmodule

// File: tb/tb_pointwise_mul.sv
// Directed bench for pointwise_mul with a scoreboard of expected vectors.
// Drives and samples 1ns after each rising edge.
module tb_pointwise_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [7:0]  mod;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic        mod_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [64:0] exp_q[$];

  pointwise_mul #(.LANES(8), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .mod_err   (mod_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [64:0] model(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [7:0]  m
  );
    logic [63:0] r;
    logic [15:0] p;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      p = {8'h00, a[8*k +: 8]} * {8'h00, b[8*k +: 8]};
      if (m != 8'd0) r[8*k +: 8] = 8'(p % {8'h00, m});
    end
    return {(m == 8'd0), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, data_out, e[63:0]);
      chk({tag, "_err"}, {63'd0, mod_err}, {63'd0, e[64]});
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] m);
    int n;
    a_in = a; b_in = b; mod = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({tag, "_ready_wait"}, {63'd0, in_ready}, 64'd1);
    exp_q.push_back(model(a, b, m));
    step();
    in_valid = 1'b0;
    a_in = ~a; b_in = ~b; mod = m + 8'd3;
    chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd8);
    check_result(tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] hold;
    int n;
    int t_prev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; mod = '0;
    step(); step();
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_err", {63'd0, mod_err}, 64'd0);
    chk("rst_rdy_low", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_high", {63'd0, in_ready}, 64'd1);

    run_vec("ramp17", 64'h0807060504030201, 64'h0202020202020202, 8'd17);
    run_vec("sq16", {8{8'd16}}, {8{8'd16}}, 8'd17);
    run_vec("sq200", {8{8'd200}}, {8{8'd200}}, 8'd251);
    run_vec("big13", 64'hFFEE9C7F40201A0D, 64'hFE0D63C8AA5511F0, 8'd13);
    run_vec("rnd255", {$urandom, $urandom}, {$urandom, $urandom}, 8'd255);
    run_vec("rnd97", {$urandom, $urandom}, {$urandom, $urandom}, 8'd97);
    run_vec("m0", {$urandom, $urandom}, {$urandom, $urandom}, 8'd0);
    run_vec("m1", {$urandom, $urandom}, {$urandom, $urandom}, 8'd1);

    // back-pressure in DONE
    a_in = 64'h1122334455667788; b_in = 64'h0102030405060708; mod = 8'd29;
    in_valid = 1'b1;
    exp_q.push_back(model(a_in, b_in, mod));
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("bp_latency", 64'(n), 64'd8);
    hold = data_out;
    check_result("bp");
    a_in = 64'hDEADBEEFCAFEF00D; b_in = 64'h0F0F0F0F0F0F0F0F; mod = 8'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data_hold", data_out, hold);
      chk("bp_ov_hold", {63'd0, out_valid}, 64'd1);
      chk("bp_rdy_low", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ov_clr", {63'd0, out_valid}, 64'd0);
    chk("bp_rdy_high", {63'd0, in_ready}, 64'd1);

    // reset on the lane-4 edge aborts the operation
    a_in = {8{8'd9}}; b_in = {8{8'd9}}; mod = 8'd50;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("abort_ov", {63'd0, out_valid}, 64'd0);
    chk("abort_data", data_out, 64'd0);
    chk("abort_rdy", {63'd0, in_ready}, 64'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) n++;
    end
    chk("abort_no_pulse", 64'(n), 64'd0);
    out_ready = 1'b0;
    run_vec("post_abort", 64'h0102030405060708, 64'h0807060504030201, 8'd11);

    // back-to-back streaming
    out_ready = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 4; i++) begin
          a_in = {$urandom, $urandom};
          b_in = {$urandom, $urandom};
          mod  = 8'($urandom_range(2, 255));
          in_valid = 1'b1;
          w = 0;
          while (!in_ready && w < 30) begin step(); w++; end
          exp_q.push_back(model(a_in, b_in, mod));
          step();
        end
        in_valid = 1'b0;
      end
      begin
        int w;
        for (int i = 0; i < 4; i++) begin
          w = 0;
          while (!out_valid && w < 40) begin step(); w++; end
          chk("b2b_seen", {63'd0, out_valid}, 64'd1);
          if (i > 0) chk("b2b_period", 64'(cyc - t_prev), 64'd10);
          t_prev = cyc;
          check_result("b2b");
          step();
        end
      end
    join
    out_ready = 1'b0;
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
